membrane_accumulator: RTL and testbench
=======================================

MEMBRANE_ACCUMULATOR -- requirements
Module: membrane_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the width of the partial sum, residue and potential data.
REQ-002 SHALL have parameter NUM_PSUM, default 3, the number of partial sums per timestep (legal range 1 to 255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have ports psum_valid (input, 1), psum_ready (output, 1) and psum_data (input, WIDTH): unsigned partial sums from the PE multiplier.
REQ-006 SHALL have ports res_valid (input, 1), res_ready (output, 1) and res_data (input, WIDTH): the residue returned by spike_residue.
REQ-007 SHALL have ports pot_valid (output, 1), pot_ready (input, 1) and pot_data (output, WIDTH): the membrane potential sent to spike_residue port L.
REQ-008 SHALL have port sat_flag, output, 1 bit: sticky overflow indicator.
REQ-009 SHALL have port busy, output, 1 bit: high when state is not ACCUM or the partial sum count is nonzero.

Function
REQ-010 SHALL complete a transfer on any channel only in a cycle where that channel's valid and ready are both 1 at the clock edge.
REQ-011 SHALL implement the FSM states ACCUM, SEND and WAIT_RES, with ACCUM as the state after reset.
REQ-012 ACCUM SHALL drive psum_ready=1, res_ready=0 and pot_valid=0.
REQ-013 In ACCUM, each psum transfer SHALL set acc <= acc + psum_data, with the width rules in REQ-021 and REQ-022, and SHALL increment cnt.
REQ-014 When the psum transfer occurs with cnt == NUM_PSUM-1, the FSM SHALL set cnt <= 0 and move to SEND.
REQ-015 SEND SHALL drive pot_valid=1, pot_data=acc, psum_ready=0 and res_ready=0; pot_valid SHALL assert the cycle after the final psum transfer.
REQ-016 In SEND, pot_data SHALL stay stable while pot_ready=0, and a pot transfer SHALL move the FSM to WAIT_RES.
REQ-017 WAIT_RES SHALL drive res_ready=1; a res transfer SHALL set acc <= res_data and move the FSM to ACCUM.
REQ-018 Inputs on a channel whose ready is 0 SHALL be ignored, including psum_valid during SEND or WAIT_RES and res_valid during ACCUM or SEND.
REQ-019 psum_valid may drop between transfers; only completed transfers SHALL count toward NUM_PSUM.
REQ-020 All ready and valid outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.
REQ-021 Accumulation SHALL compute the sum at WIDTH+1 bits, unsigned.
REQ-022 Overflow handling SHALL be set by REQ-029 and REQ-030.
REQ-023 sat_flag SHALL be set in the cycle an overflow is detected and cleared only by rst.
REQ-024 pot_data SHALL read 0 whenever pot_valid=0.

Reset
REQ-025 While rst=1, the block SHALL immediately force state=ACCUM, acc=0, cnt=0 and sat_flag=0.
REQ-026 During reset, the outputs SHALL be psum_ready=1, res_ready=0, pot_valid=0, pot_data=0 and busy=0.
REQ-027 Reset asserted mid-timestep or in SEND SHALL discard the partial accumulation, and any pending potential SHALL NOT be emitted.
REQ-028 The first timestep after reset SHALL start from acc=0, with no residue expected.

Configuration
REQ-029 When macro ACC_SATURATE_EN is defined, a sum greater than 2^WIDTH-1 SHALL clamp acc to 2^WIDTH-1 and set sat_flag.
REQ-030 When ACC_SATURATE_EN is undefined, the sum SHALL wrap modulo 2^WIDTH and sat_flag SHALL be tied to 0.

Verification
REQ-031 With WIDTH=8 and NUM_PSUM=3, after reset send psums 10, 20, 30 -> pot_valid=1 with pot_data=60 one cycle after the 3rd transfer.
REQ-032 After REQ-031, return res 4, then send psums 1, 2, 3 -> pot_data=10.
REQ-033 Send psums 200, 100, 0 -> with ACC_SATURATE_EN, pot_data=255 and sat_flag=1; without it, pot_data=44 and sat_flag=0.
REQ-034 Hold pot_ready=0 for 5 cycles in SEND while psum_valid=1 -> pot_data stays constant, psum_ready=0, and no psum is consumed.
REQ-035 Assert rst after 2 psums of 5 and 6 -> the same cycle shows acc=0, busy=0 and pot_valid=0; the next psums 1, 1, 1 -> pot_data=3.
REQ-036 Insert idle cycles (psum_valid=0) between psums 7, 8, 9 -> pot_data=24, and busy=1 throughout the gaps.

Source files
------------

// File: rtl/membrane_accumulator.sv
// rtl/membrane_accumulator.sv - accumulates NUM_PSUM partial sums per timestep into a membrane potential
// Optional feature: define ACC_SATURATE_EN to clamp on overflow and drive sat_flag (default build wraps).
module membrane_accumulator #(
  parameter int WIDTH    = 8,
  parameter int NUM_PSUM = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psum_valid,
  output logic             psum_ready,
  input  logic [WIDTH-1:0] psum_data,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] res_data,
  output logic             pot_valid,
  input  logic             pot_ready,
  output logic [WIDTH-1:0] pot_data,
  output logic             sat_flag,
  output logic             busy
);

  localparam logic [1:0] ACCUM    = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] WAIT_RES = 2'd2;
  localparam logic [7:0] LAST_CNT = 8'(NUM_PSUM - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [7:0]       cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_next;
  logic             psum_fire;
  logic             res_fire;
  logic             pot_fire;

  // Handshake outputs decode registered state only, keeping inputs off output paths.
  assign psum_ready = (state == ACCUM);
  assign res_ready  = (state == WAIT_RES);
  assign pot_valid  = (state == SEND);
  assign pot_data   = pot_valid ? acc : '0;
  assign busy       = (state != ACCUM) || (cnt != 8'd0);

  assign psum_fire = psum_valid && psum_ready;
  assign res_fire  = res_valid && res_ready;
  assign pot_fire  = pot_valid && pot_ready;

  assign sum = {1'b0, acc} + {1'b0, psum_data};

`ifdef ACC_SATURATE_EN
  assign acc_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (psum_fire && sum[WIDTH]) begin
      sat_flag <= 1'b1;
    end
  end
`else
  logic unused_carry;
  assign unused_carry = sum[WIDTH];
  assign acc_next     = sum[WIDTH-1:0];
  assign sat_flag     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= 8'd0;
    end else begin
      case (state)
        ACCUM: begin
          if (psum_fire) begin
            acc <= acc_next;
            if (cnt == LAST_CNT) begin
              cnt   <= 8'd0;
              state <= SEND;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        SEND: begin
          if (pot_fire) begin
            state <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (res_fire) begin
            acc   <= res_data;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_membrane_accumulator.sv
// tb/tb_membrane_accumulator.sv - scoreboard bench for membrane_accumulator (WIDTH=8, NUM_PSUM=3)
module tb_membrane_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       psum_valid;
  logic       psum_ready;
  logic [7:0] psum_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       pot_valid;
  logic       pot_ready;
  logic [7:0] pot_data;
  logic       sat_flag;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic       exp_sat;

  membrane_accumulator #(.WIDTH(8), .NUM_PSUM(3)) dut (
    .clk(clk), .rst(rst),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .pot_valid(pot_valid), .pot_ready(pot_ready), .pot_data(pot_data),
    .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pot transfers are sampled on the falling edge before the rising edge that completes them.
  always @(negedge clk) begin
    if (!rst && pot_valid && pot_ready) begin
      logic [8:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pot_unexpected: got pot_data %0d expected no transfer", pot_data);
      end else begin
        e = exp_q.pop_front();
        if (pot_data !== e[7:0] || sat_flag !== e[8]) begin
          errors++;
          $display("FAIL pot_data/sat: got %0d/%0b expected %0d/%0b", pot_data, sat_flag, e[7:0], e[8]);
        end
      end
    end
  end

  task automatic expect_pot(input logic [7:0] v, input logic sat);
    exp_q.push_back({sat, v});
  endtask

  // Tasks start and end at posedge+#1.
  task automatic send_psum(input logic [7:0] v);
    logic got = 1'b0;
    psum_valid = 1'b1;
    psum_data  = v;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (psum_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL psum_timeout: got psum_ready 0 expected 1");
    end
    @(posedge clk); #1;
    psum_valid = 1'b0;
  endtask

  task automatic send_res(input logic [7:0] v);
    logic got = 1'b0;
    res_valid = 1'b1;
    res_data  = v;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (res_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL res_timeout: got res_ready 0 expected 1");
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("busy_gap", {7'd0, busy}, 8'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; psum_valid = 1'b0; psum_data = '0;
    res_valid = 1'b0; res_data = '0; pot_ready = 1'b1; exp_sat = 1'b0;
    #1;
    check("rst_psum_ready", {7'd0, psum_ready}, 8'd1);
    check("rst_res_ready",  {7'd0, res_ready},  8'd0);
    check("rst_pot_valid",  {7'd0, pot_valid},  8'd0);
    check("rst_pot_data",   pot_data,           8'd0);
    check("rst_busy",       {7'd0, busy},       8'd0);
    check("rst_sat_flag",   {7'd0, sat_flag},   8'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic timestep from reset: 10+20+30.
    expect_pot(8'd60, exp_sat);
    send_psum(8'd10); send_psum(8'd20); send_psum(8'd30);
    check("pot_valid_after_last", {7'd0, pot_valid}, 8'd1);
    @(negedge clk); @(posedge clk); #1;
    check("wait_res_ready",  {7'd0, res_ready},  8'd1);
    check("wait_psum_ready", {7'd0, psum_ready}, 8'd0);
    check("wait_pot_data",   pot_data,           8'd0);
    check("wait_busy",       {7'd0, busy},       8'd1);

    // Residue seeds the next timestep: 4+1+2+3.
    send_res(8'd4);
    expect_pot(8'd10, exp_sat);
    send_psum(8'd1); send_psum(8'd2); send_psum(8'd3);
    send_res(8'd0);

    // Overflow: 200+100+0.
`ifdef ACC_SATURATE_EN
    exp_sat = 1'b1;
    expect_pot(8'd255, exp_sat);
`else
    expect_pot(8'd44, exp_sat);
`endif
    send_psum(8'd200); send_psum(8'd100); send_psum(8'd0);
    check("sat_flag_after_ovf", {7'd0, sat_flag}, {7'd0, exp_sat});
    send_res(8'd0);

    // Backpressure on pot with psum_valid held high.
    pot_ready = 1'b0;
    expect_pot(8'd6, exp_sat);
    send_psum(8'd1); send_psum(8'd2); send_psum(8'd3);
    psum_valid = 1'b1; psum_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_pot_data",   pot_data,           8'd6);
      check("hold_pot_valid",  {7'd0, pot_valid},  8'd1);
      check("hold_psum_ready", {7'd0, psum_ready}, 8'd0);
      @(posedge clk); #1;
    end
    pot_ready = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    psum_valid = 1'b0;
    send_res(8'd0);

    // Reset mid-timestep discards 5+6.
    send_psum(8'd5); send_psum(8'd6);
    rst = 1'b1;
    #1;
    check("midrst_busy",      {7'd0, busy},      8'd0);
    check("midrst_pot_valid", {7'd0, pot_valid}, 8'd0);
    check("midrst_sat_flag",  {7'd0, sat_flag},  8'd0);
    exp_sat = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    expect_pot(8'd3, exp_sat);
    send_psum(8'd1); send_psum(8'd1); send_psum(8'd1);
    send_res(8'd0);

    // Gaps between psums: busy stays high, only transfers count.
    expect_pot(8'd24, exp_sat);
    send_psum(8'd7); idle(3);
    send_psum(8'd8); idle(2);
    send_psum(8'd9);
    repeat (3) begin @(negedge clk); @(posedge clk); #1; end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
